// File: rtl/ram_dq_arb.sv
// ram_dq_arb: round-robin burst arbiter and address sequencer in front of the
// shared 16-bit byte-enabled single-port packet RAM. Requester A is the DMA
// engine, requester B the host register/debug path. Whole bursts are granted,
// one RAM access is issued per cycle, and read data returns one cycle after
// each read beat.
module ram_dq_arb #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 1024,
  parameter int LEN_W  = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  // requester A (DMA engine)
  input  logic              a_req,
  input  logic              a_we,
  input  logic [1:0]        a_be,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [LEN_W-1:0]  a_len,
  output logic              a_gnt,
  output logic              a_beat,
  input  logic [15:0]       a_wdata,
  output logic              a_rvalid,
  // requester B (host register/debug)
  input  logic              b_req,
  input  logic              b_we,
  input  logic [1:0]        b_be,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [LEN_W-1:0]  b_len,
  output logic              b_gnt,
  output logic              b_beat,
  input  logic [15:0]       b_wdata,
  output logic              b_rvalid,
  // shared status / read return
  output logic [15:0]       rdata,
  output logic              busy,
  // RAM side
  output logic              ram_ClockEn,
  output logic              ram_WE,
  output logic [1:0]        ram_ByteEn,
  output logic [ADDR_W-1:0] ram_Address,
  output logic [15:0]       ram_Data,
  input  logic [15:0]       ram_Q
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Wrap is an equality test only: a start address beyond the last word
  // simply keeps counting until it rolls over the full address width.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] cur);
    if (cur == LAST_ADDR) begin
      next_addr = {ADDR_W{1'b0}};
    end else begin
      next_addr = cur + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_t             state_r, state_s;
  logic               owner_r, owner_s;
  logic               last_r, last_s;
  logic               we_r, we_s;
  logic [1:0]         be_r, be_s;
  logic [ADDR_W-1:0]  addr_r, addr_s;
  logic [LEN_W-1:0]   len_r, len_s;
  logic [LEN_W-1:0]   cnt_r, cnt_s;
  logic               a_gnt_r, a_gnt_s;
  logic               b_gnt_r, b_gnt_s;
  logic               a_rvalid_r, b_rvalid_r;
  logic               beat_s;
  logic               a_beat_s, b_beat_s;
  logic [15:0]        ram_data_s;

  // Arbitration in IDLE and beat sequencing in BURST.
  always_comb begin
    state_s = state_r;
    owner_s = owner_r;
    last_s  = last_r;
    we_s    = we_r;
    be_s    = be_r;
    addr_s  = addr_r;
    len_s   = len_r;
    cnt_s   = cnt_r;
    a_gnt_s = 1'b0;
    b_gnt_s = 1'b0;
    case (state_r)
      IDLE: begin
        // A wins when alone, or on a tie when B owned the previous burst.
        if (a_req && (!b_req || (last_r == OWN_B))) begin
          state_s = BURST;
          owner_s = OWN_A;
          we_s    = a_we;
          be_s    = a_be;
          addr_s  = a_addr;
          len_s   = a_len;
          cnt_s   = {LEN_W{1'b0}};
          a_gnt_s = 1'b1;
        end else if (b_req) begin
          state_s = BURST;
          owner_s = OWN_B;
          we_s    = b_we;
          be_s    = b_be;
          addr_s  = b_addr;
          len_s   = b_len;
          cnt_s   = {LEN_W{1'b0}};
          b_gnt_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      BURST: begin
        addr_s = next_addr(addr_r);
        cnt_s  = cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
        if (cnt_r == len_r) begin
          state_s = IDLE;
          last_s  = owner_r;
        end else begin
          state_s = BURST;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Burst state, grant pulses and read-return flags.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r    <= IDLE;
      owner_r    <= OWN_A;
      last_r     <= OWN_B;
      we_r       <= 1'b0;
      be_r       <= 2'b00;
      addr_r     <= {ADDR_W{1'b0}};
      len_r      <= {LEN_W{1'b0}};
      cnt_r      <= {LEN_W{1'b0}};
      a_gnt_r    <= 1'b0;
      b_gnt_r    <= 1'b0;
      a_rvalid_r <= 1'b0;
      b_rvalid_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      owner_r    <= owner_s;
      last_r     <= last_s;
      we_r       <= we_s;
      be_r       <= be_s;
      addr_r     <= addr_s;
      len_r      <= len_s;
      cnt_r      <= cnt_s;
      a_gnt_r    <= a_gnt_s;
      b_gnt_r    <= b_gnt_s;
      a_rvalid_r <= a_beat_s && !we_r;
      b_rvalid_r <= b_beat_s && !we_r;
    end
  end

  // Beat ownership is decoded purely from registered state.
  assign beat_s   = (state_r == BURST);
  assign a_beat_s = beat_s && (owner_r == OWN_A);
  assign b_beat_s = beat_s && (owner_r == OWN_B);

  // Write data is taken from the owning requester in the beat cycle itself.
  always_comb begin
    ram_data_s = 16'h0000;
    if (beat_s && we_r) begin
      if (owner_r == OWN_B) begin
        ram_data_s = b_wdata;
      end else begin
        ram_data_s = a_wdata;
      end
    end else begin
      ram_data_s = 16'h0000;
    end
  end

  assign a_gnt       = a_gnt_r;
  assign b_gnt       = b_gnt_r;
  assign a_beat      = a_beat_s;
  assign b_beat      = b_beat_s;
  assign a_rvalid    = a_rvalid_r;
  assign b_rvalid    = b_rvalid_r;
  assign rdata       = ram_Q;
  assign busy        = beat_s;
  assign ram_ClockEn = 1'b1;
  assign ram_WE      = beat_s && we_r;
  assign ram_ByteEn  = (beat_s && we_r) ? be_r : 2'b00;
  assign ram_Address = beat_s ? addr_r : {ADDR_W{1'b0}};
  assign ram_Data    = ram_data_s;

endmodule
